uart_rx_datapath: RTL

Bit-level receive datapath for the UART receiver. It runs beside `RXFSM` and closes the loop with it:
- It produces `start_bit_detected` and `parity_error` for the FSM.
- It consumes the FSM's `run_shift`, `parity_load` and `chk_stop` strobes to shift in 8 data bits, check parity and check the stop bit.
- It presents each accepted byte on a valid/ready handshake to the host side, together with status pulses.
- The line is sampled once per `clock`; one clock equals one bit time.

---
 rtl/uart_rx_datapath.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx_datapath.sv
// Bit-level UART receive datapath: line synchronizer, start detector, shift/parity/stop
// checking driven by the receive FSM strobes, and a valid/ready byte output with status pulses.
module uart_rx_datapath #(
  parameter int PARITY_ODD    = 0,
  parameter int REARM_TIMEOUT = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  input  logic       run_shift,
  input  logic       parity_load,
  input  logic       chk_stop,
  output logic       start_bit_detected,
  output logic       parity_error,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err_pulse,
  output logic       frame_err_pulse,
  output logic       overrun_pulse
);

  localparam logic [3:0] REARM_T   = 4'(REARM_TIMEOUT);
  localparam logic       PAR_SENSE = 1'(PARITY_ODD);

  logic       rx_meta_r;
  logic       rx_sync_r;
  logic       rx_prev_r;
  logic       armed_r;
  logic [3:0] timer_r;
  logic [7:0] shreg_r;
  logic       par_r;

  logic       byte_done_s;
  logic       frame_bad_s;
  logic       rearm_s;

  function automatic logic parity_mismatch(input logic bit_in, input logic acc, input logic odd);
    return bit_in ^ acc ^ odd;
  endfunction

  assign start_bit_detected = armed_r & rx_prev_r & ~rx_sync_r;
  assign parity_error       = parity_load & parity_mismatch(rx_sync_r, par_r, PAR_SENSE);

  // Frame-end decode; the timer term recovers the detector if the FSM never closes a frame
  always_comb begin
    byte_done_s = chk_stop & rx_sync_r;
    frame_bad_s = chk_stop & ~rx_sync_r;
    rearm_s     = chk_stop | parity_error | (timer_r == REARM_T);
  end

  // Two-flop synchronizer plus previous-sample flop, all idling high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_serial;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Armed flag and saturating frame timer; a start always wins over a rearm
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_r <= 1'b1;
      timer_r <= 4'd0;
    end else if (start_bit_detected) begin
      armed_r <= 1'b0;
      timer_r <= 4'd0;
    end else begin
      if (rearm_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
      if (!armed_r && (timer_r != 4'hF)) begin
        timer_r <= timer_r + 4'd1;
      end else begin
        timer_r <= timer_r;
      end
    end
  end

  // LSB-first shift register with running parity of the shifted bits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_r <= 8'h00;
      par_r   <= 1'b0;
    end else begin
      if (run_shift) begin
        shreg_r <= {rx_sync_r, shreg_r[7:1]};
      end else begin
        shreg_r <= shreg_r;
      end
      if (start_bit_detected) begin
        par_r <= 1'b0;
      end else if (run_shift) begin
        par_r <= par_r ^ rx_sync_r;
      end else begin
        par_r <= par_r;
      end
    end
  end

  // Host handshake and status pulses; an unread byte is kept and the newcomer dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data          <= 8'h00;
      rx_valid         <= 1'b0;
      parity_err_pulse <= 1'b0;
      frame_err_pulse  <= 1'b0;
      overrun_pulse    <= 1'b0;
    end else begin
      parity_err_pulse <= parity_error;
      frame_err_pulse  <= frame_bad_s;
      overrun_pulse    <= byte_done_s & rx_valid & ~rx_ready;
      if (byte_done_s) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg_r;
          rx_valid <= 1'b1;
        end else begin
          rx_data  <= rx_data;
          rx_valid <= rx_valid;
        end
      end else if (rx_ready) begin
        rx_data  <= rx_data;
        rx_valid <= 1'b0;
      end else begin
        rx_data  <= rx_data;
        rx_valid <= rx_valid;
      end
    end
  end

endmodule
